// File: rtl/serializzatore_pkg.sv
// Shared definitions for the hit serializer: parameter defaults, FSM state
// encoding and the mask scan used to pick the next hit to emit.
package serializzatore_pkg;

   localparam int N_HIT_DEF    = 6;
   localparam int HIT_W_DEF    = 16;
   localparam int N_CONST_DEF  = 6;
   localparam int CONST_W_DEF  = 18;
   localparam int PIPE_LAT_DEF = 2;
   localparam int SKIP_EN_DEF  = 0;

   // Widest hit mask the scan function accepts.
   localparam int MAX_HIT = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EMIT   = 2'd1,
      EE_OUT = 2'd2
   } state_t;

   // Lowest selected hit index >= start; returns n_hit when none is left.
   // With skip_en clear every index below n_hit counts as selected.
   // start = 0 gives the first hit, start = idx + 1 gives the next one.
   function automatic int unsigned next_sel(
      input logic [MAX_HIT-1:0] mask,
      input int unsigned        start,
      input int unsigned        n_hit,
      input bit                 skip_en
   );
      int unsigned sel;
      logic        found;
      sel   = n_hit;
      found = 1'b0;
      for (int unsigned i = 0; i < MAX_HIT; i++) begin
         if (!found && i >= start && i < n_hit && (!skip_en || mask[i])) begin
            sel   = i;
            found = 1'b1;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/serializzatore_gen_if.sv
// Input combination handshake plus the serialized output bundle.
// master = producer/consumer side, slave = the serializer.
interface serializzatore_gen_if
   import serializzatore_pkg::*;
#(
   parameter int N_HIT   = N_HIT_DEF,
   parameter int HIT_W   = HIT_W_DEF,
   parameter int N_CONST = N_CONST_DEF,
   parameter int CONST_W = CONST_W_DEF
);
   localparam int IDX_W = (N_HIT > 1) ? $clog2(N_HIT) : 1;
   localparam int BLK_W = N_CONST * CONST_W;

   logic                         in_valid;
   logic                         in_ready;
   logic                         comb_ee;
   logic [N_HIT*HIT_W-1:0]       comb_data;
   logic [N_HIT-1:0]             hit_mask;
   logic [(N_HIT+1)*BLK_W-1:0]   const_data;

   logic [HIT_W-1:0]             out_ser;
   logic                         dv;
   logic                         ev;
   logic                         ee;
   logic [IDX_W-1:0]             hit_idx;
   logic [BLK_W-1:0]             c_term;
   logic [BLK_W-1:0]             c_offset;

   modport master (
      output in_valid, comb_ee, comb_data, hit_mask, const_data,
      input  in_ready, out_ser, dv, ev, ee, hit_idx, c_term, c_offset
   );

   modport slave (
      input  in_valid, comb_ee, comb_data, hit_mask, const_data,
      output in_ready, out_ser, dv, ev, ee, hit_idx, c_term, c_offset
   );

endinterface

// File: rtl/ser_delay_line.sv
// Fixed-latency delay line; DEPTH = 0 degenerates to a plain wire.
module ser_delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   generate
      if (DEPTH == 0) begin : g_wire
         logic unused_clk_rst;
         assign unused_clk_rst = clock ^ reset;
         assign q = d;
      end else begin : g_pipe
         logic [WIDTH-1:0] stage [DEPTH];

         // Shift the bundle one stage per cycle.
         // NOTE: every stage is reset, otherwise stale dv/ev bits would leak
         // out during the first DEPTH cycles after reset release.
         always_ff @(posedge clock) begin
            if (reset) begin
               for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
            end else begin
               stage[0] <= d;
               for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
         end

         assign q = stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/serializzatore_gen.sv
// Hit serializer: accepts one combination of N_HIT hits (plus constant
// blocks) and emits the selected hits one per cycle, followed by a fixed
// PIPE_LAT output delay shared by the whole output bundle.
module serializzatore_gen
   import serializzatore_pkg::*;
#(
   parameter int N_HIT    = N_HIT_DEF,
   parameter int HIT_W    = HIT_W_DEF,
   parameter int N_CONST  = N_CONST_DEF,
   parameter int CONST_W  = CONST_W_DEF,
   parameter int PIPE_LAT = PIPE_LAT_DEF,
   parameter int SKIP_EN  = SKIP_EN_DEF
) (
   input logic                clock,
   input logic                reset,
   serializzatore_gen_if.slave bus
);

   localparam int  IDX_W  = (N_HIT > 1) ? $clog2(N_HIT) : 1;
   localparam int  BLK_W  = N_CONST * CONST_W;
   localparam int  BUS_W  = 3 + IDX_W + HIT_W + BLK_W;
   localparam bit  SKIP_B = (SKIP_EN != 0);

   state_t                     state;
   logic [IDX_W-1:0]           idx;
   logic [N_HIT*HIT_W-1:0]     comb_q;
   logic [N_HIT-1:0]           mask_q;
   logic [(N_HIT+1)*BLK_W-1:0] const_q;

   // Issue stage: the hit being issued this cycle, registered ahead of the
   // delay line so constants are chosen together with the hit.
   logic                       s_dv;
   logic                       s_ev;
   logic                       s_ee;
   logic [IDX_W-1:0]           s_idx;
   logic [HIT_W-1:0]           s_ser;
   logic [BLK_W-1:0]           s_term;

   int unsigned                in_first;
   int unsigned                in_second;
   int unsigned                in_sel;
   int unsigned                q_next;
   int unsigned                q_after;
   int unsigned                q_sel;
   logic                       in_ready_c;
   logic                       accept;

   logic [BUS_W-1:0]           pipe_d;
   logic [BUS_W-1:0]           pipe_q;

   // Mask scans for the offered combination and for the one being emitted.
   // NOTE: each variable is assigned on every pass, so no latch can form.
   always_comb begin
      in_first  = next_sel(MAX_HIT'(bus.hit_mask), 0, N_HIT, SKIP_B);
      in_second = next_sel(MAX_HIT'(bus.hit_mask), in_first + 1, N_HIT, SKIP_B);
      in_sel    = (in_first < N_HIT) ? in_first : 0;
      q_next    = next_sel(MAX_HIT'(mask_q), 32'(idx) + 1, N_HIT, SKIP_B);
      q_after   = next_sel(MAX_HIT'(mask_q), q_next + 1, N_HIT, SKIP_B);
      q_sel     = (q_next < N_HIT) ? q_next : 0;
   end

   // Ready in IDLE, or while the last selected hit is being issued.
   assign in_ready_c = (state == IDLE) || (state == EMIT && s_ev && s_dv);
   assign accept     = bus.in_valid && in_ready_c;

   // Control FSM with registered issue-stage outputs.
   // NOTE: non-blocking assignments keep every register sampling the
   // pre-edge values, independent of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         idx     <= '0;
         comb_q  <= '0;
         mask_q  <= '0;
         const_q <= '0;
         s_dv    <= 1'b0;
         s_ev    <= 1'b0;
         s_ee    <= 1'b0;
         s_idx   <= '0;
         s_ser   <= '0;
         s_term  <= '0;
      end else begin
         s_dv   <= 1'b0;
         s_ev   <= 1'b0;
         s_ee   <= 1'b0;
         s_idx  <= '0;
         s_ser  <= '0;
         s_term <= '0;
         if (accept) begin
            if (bus.comb_ee) begin
               state <= EE_OUT;
               s_ee  <= 1'b1;
            end else begin
               comb_q  <= bus.comb_data;
               mask_q  <= bus.hit_mask;
               const_q <= bus.const_data;
               state   <= EMIT;
               if (in_first < N_HIT) begin
                  idx    <= IDX_W'(in_sel);
                  s_dv   <= 1'b1;
                  s_ev   <= (in_second >= N_HIT);
                  s_idx  <= IDX_W'(in_sel);
                  s_ser  <= bus.comb_data[in_sel*HIT_W +: HIT_W];
                  s_term <= bus.const_data[(in_sel+1)*BLK_W +: BLK_W];
               end else begin
                  // Empty combination: a single ev-only cycle.
                  idx  <= '0;
                  s_ev <= 1'b1;
               end
            end
         end else begin
            case (state)
               EMIT: begin
                  if (s_ev) begin
                     state <= IDLE;
                  end else begin
                     idx    <= IDX_W'(q_sel);
                     s_dv   <= 1'b1;
                     s_ev   <= (q_after >= N_HIT);
                     s_idx  <= IDX_W'(q_sel);
                     s_ser  <= comb_q[q_sel*HIT_W +: HIT_W];
                     s_term <= const_q[(q_sel+1)*BLK_W +: BLK_W];
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign pipe_d = {s_dv, s_ev, s_ee, s_idx, s_ser, s_term};

   ser_delay_line #(
      .WIDTH(BUS_W),
      .DEPTH(PIPE_LAT)
   ) u_delay (
      .clock(clock),
      .reset(reset),
      .d    (pipe_d),
      .q    (pipe_q)
   );

   assign {bus.dv, bus.ev, bus.ee, bus.hit_idx, bus.out_ser, bus.c_term} = pipe_q;
   assign bus.c_offset = const_q[BLK_W-1:0];
   assign bus.in_ready = in_ready_c;

endmodule

// File: tb/tb_serializzatore_gen.sv
// Directed bench for serializzatore_gen: four instances cover the default
// configuration, SKIP_EN=1, PIPE_LAT=0 and N_HIT=8/HIT_W=12.
module tb_serializzatore_gen;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   always #5 clock = ~clock;

   serializzatore_gen_if                          if0 ();
   serializzatore_gen_if                          if1 ();
   serializzatore_gen_if                          if2 ();
   serializzatore_gen_if #(.N_HIT(8), .HIT_W(12)) if3 ();

   serializzatore_gen dut0 (.clock(clock), .reset(reset), .bus(if0.slave));
   serializzatore_gen #(.SKIP_EN(1)) dut1 (.clock(clock), .reset(reset), .bus(if1.slave));
   serializzatore_gen #(.PIPE_LAT(0)) dut2 (.clock(clock), .reset(reset), .bus(if2.slave));
   serializzatore_gen #(.N_HIT(8), .HIT_W(12)) dut3 (.clock(clock), .reset(reset), .bus(if3.slave));

   logic [971:0] cvec;
   logic         e_dv, e_ev, e_ee, e_rdy;
   logic [2:0]   e_idx;
   logic [15:0]  e_ser;
   logic [107:0] e_term;

   // Constant block b: six 18-bit words b*256 + j + 1.
   function automatic logic [107:0] blk(input int b);
      logic [107:0] r;
      for (int j = 0; j < 6; j++) r[j*18 +: 18] = 18'(b*256 + j + 1);
      return r;
   endfunction

   function automatic logic [95:0] hits16(input int base);
      logic [95:0] r;
      for (int k = 0; k < 6; k++) r[k*16 +: 16] = 16'(base + k);
      return r;
   endfunction

   function automatic logic [95:0] hits12(input int base);
      logic [95:0] r;
      for (int k = 0; k < 8; k++) r[k*12 +: 12] = 12'(base + k);
      return r;
   endfunction

   task automatic clear_exp();
      e_dv = 1'b0; e_ev = 1'b0; e_ee = 1'b0; e_rdy = 1'b0;
      e_idx = '0; e_ser = '0; e_term = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      checks++;
      if ({if0.in_ready, if1.in_ready, if2.in_ready, if3.in_ready} !== 4'hF) begin
         failures++;
         $display("FAIL reset_ready got=%b expected=1111",
                  {if0.in_ready, if1.in_ready, if2.in_ready, if3.in_ready});
      end
      checks++;
      if ({if0.dv, if0.ev, if0.ee, if0.hit_idx} !== 6'd0 || if0.out_ser !== 16'd0 ||
          if0.c_term !== 108'd0 || if0.c_offset !== 108'd0) begin
         failures++;
         $display("FAIL reset_outputs got dv=%b ev=%b ee=%b idx=%0d ser=%h term=%h off=%h expected all zero",
                  if0.dv, if0.ev, if0.ee, if0.hit_idx, if0.out_ser, if0.c_term, if0.c_offset);
      end
   endtask

   task automatic test_single();
      @(posedge clock); #1;
      if0.comb_data  = hits16(1);
      if0.hit_mask   = 6'h3F;
      if0.const_data = cvec[755:0];
      if0.comb_ee    = 1'b0;
      if0.in_valid   = 1'b1;
      @(posedge clock); #1 if0.in_valid = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clock);
         clear_exp();
         e_rdy = (c >= 6);
         if (c >= 3 && c <= 8) begin
            e_dv = 1'b1; e_ev = (c == 8); e_idx = 3'(c - 3);
            e_ser = 16'(c - 2); e_term = blk(c - 2);
         end
         checks++;
         if ({if0.dv, if0.ev, if0.ee, if0.in_ready, if0.hit_idx, if0.out_ser, if0.c_term} !==
             {e_dv, e_ev, e_ee, e_rdy, e_idx, e_ser, e_term}) begin
            failures++;
            $display("FAIL single c=%0d got dv=%b ev=%b ee=%b rdy=%b idx=%0d ser=%h term=%h, expected dv=%b ev=%b ee=%b rdy=%b idx=%0d ser=%h term=%h",
                     c, if0.dv, if0.ev, if0.ee, if0.in_ready, if0.hit_idx, if0.out_ser, if0.c_term,
                     e_dv, e_ev, e_ee, e_rdy, e_idx, e_ser, e_term);
         end
         if (c == 1 || c == 9) begin
            checks++;
            if (if0.c_offset !== blk(0)) begin
               failures++;
               $display("FAIL single_offset c=%0d got=%h expected=%h", c, if0.c_offset, blk(0));
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      @(posedge clock); #1;
      if0.comb_data = hits16(16'h11);
      if0.hit_mask  = 6'h3F;
      if0.in_valid  = 1'b1;
      @(posedge clock); #1;
      if0.comb_data = hits16(16'h21);
      for (int c = 1; c <= 15; c++) begin
         @(negedge clock);
         clear_exp();
         e_rdy = (c == 6) || (c >= 12);
         if (c >= 3 && c <= 8) begin
            e_dv = 1'b1; e_ev = (c == 8); e_idx = 3'(c - 3);
            e_ser = 16'(16'h11 + c - 3); e_term = blk(c - 2);
         end else if (c >= 9 && c <= 14) begin
            e_dv = 1'b1; e_ev = (c == 14); e_idx = 3'(c - 9);
            e_ser = 16'(16'h21 + c - 9); e_term = blk(c - 8);
         end
         checks++;
         if ({if0.dv, if0.ev, if0.ee, if0.in_ready, if0.hit_idx, if0.out_ser, if0.c_term} !==
             {e_dv, e_ev, e_ee, e_rdy, e_idx, e_ser, e_term}) begin
            failures++;
            $display("FAIL back_to_back c=%0d got dv=%b ev=%b ee=%b rdy=%b idx=%0d ser=%h term=%h, expected dv=%b ev=%b ee=%b rdy=%b idx=%0d ser=%h term=%h",
                     c, if0.dv, if0.ev, if0.ee, if0.in_ready, if0.hit_idx, if0.out_ser, if0.c_term,
                     e_dv, e_ev, e_ee, e_rdy, e_idx, e_ser, e_term);
         end
         if (c == 6) begin
            @(posedge clock); #1 if0.in_valid = 1'b0;
         end
      end
   endtask

   task automatic test_end_event();
      @(posedge clock); #1;
      if0.comb_ee  = 1'b1;
      if0.in_valid = 1'b1;
      @(posedge clock); #1;
      if0.in_valid = 1'b0;
      if0.comb_ee  = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clock);
         clear_exp();
         e_rdy = (c >= 2);
         e_ee  = (c == 3);
         checks++;
         if ({if0.dv, if0.ev, if0.ee, if0.in_ready, if0.hit_idx, if0.out_ser, if0.c_term} !==
             {e_dv, e_ev, e_ee, e_rdy, e_idx, e_ser, e_term}) begin
            failures++;
            $display("FAIL end_event c=%0d got dv=%b ev=%b ee=%b rdy=%b idx=%0d ser=%h, expected dv=%b ev=%b ee=%b rdy=%b idx=%0d ser=%h",
                     c, if0.dv, if0.ev, if0.ee, if0.in_ready, if0.hit_idx, if0.out_ser,
                     e_dv, e_ev, e_ee, e_rdy, e_idx, e_ser);
         end
      end
   endtask

   task automatic test_skip();
      int sel [3];
      sel = '{0, 2, 5};
      @(posedge clock); #1;
      if1.comb_data  = hits16(16'hA0);
      if1.hit_mask   = 6'b100101;
      if1.const_data = cvec[755:0];
      if1.comb_ee    = 1'b0;
      if1.in_valid   = 1'b1;
      @(posedge clock); #1 if1.in_valid = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clock);
         clear_exp();
         e_rdy = (c >= 3);
         if (c >= 3 && c <= 5) begin
            e_dv = 1'b1; e_ev = (c == 5); e_idx = 3'(sel[c-3]);
            e_ser = 16'(16'hA0 + sel[c-3]); e_term = blk(sel[c-3] + 1);
         end
         checks++;
         if ({if1.dv, if1.ev, if1.ee, if1.in_ready, if1.hit_idx, if1.out_ser, if1.c_term} !==
             {e_dv, e_ev, e_ee, e_rdy, e_idx, e_ser, e_term}) begin
            failures++;
            $display("FAIL skip c=%0d got dv=%b ev=%b ee=%b rdy=%b idx=%0d ser=%h term=%h, expected dv=%b ev=%b ee=%b rdy=%b idx=%0d ser=%h term=%h",
                     c, if1.dv, if1.ev, if1.ee, if1.in_ready, if1.hit_idx, if1.out_ser, if1.c_term,
                     e_dv, e_ev, e_ee, e_rdy, e_idx, e_ser, e_term);
         end
      end
      // Empty mask: one ev-only cycle, then ready again.
      @(posedge clock); #1;
      if1.hit_mask = 6'b000000;
      if1.in_valid = 1'b1;
      @(posedge clock); #1 if1.in_valid = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clock);
         clear_exp();
         e_rdy = (c >= 2);
         e_ev  = (c == 3);
         checks++;
         if ({if1.dv, if1.ev, if1.ee, if1.in_ready, if1.hit_idx, if1.out_ser, if1.c_term} !==
             {e_dv, e_ev, e_ee, e_rdy, e_idx, e_ser, e_term}) begin
            failures++;
            $display("FAIL skip_empty c=%0d got dv=%b ev=%b ee=%b rdy=%b idx=%0d ser=%h, expected dv=%b ev=%b ee=%b rdy=%b idx=%0d ser=%h",
                     c, if1.dv, if1.ev, if1.ee, if1.in_ready, if1.hit_idx, if1.out_ser,
                     e_dv, e_ev, e_ee, e_rdy, e_idx, e_ser);
         end
      end
   endtask

   task automatic test_reset_mid_emit();
      @(posedge clock); #1;
      if0.comb_data = hits16(1);
      if0.hit_mask  = 6'h3F;
      if0.in_valid  = 1'b1;
      @(posedge clock); #1 if0.in_valid = 1'b0;
      @(posedge clock); #1;
      @(posedge clock); #1 reset = 1'b1;
      @(posedge clock); #1 reset = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clock);
         if (c == 1) begin
            checks++;
            if (if0.in_ready !== 1'b1) begin
               failures++;
               $display("FAIL reset_mid_ready got=%b expected=1", if0.in_ready);
            end
         end
         checks++;
         if ({if0.dv, if0.ev, if0.ee} !== 3'b000) begin
            failures++;
            $display("FAIL reset_mid c=%0d got dv=%b ev=%b ee=%b expected 0 0 0",
                     c, if0.dv, if0.ev, if0.ee);
         end
      end
   endtask

   task automatic test_lat0();
      @(posedge clock); #1;
      if2.comb_data  = hits16(1);
      if2.hit_mask   = 6'h3F;
      if2.const_data = cvec[755:0];
      if2.comb_ee    = 1'b0;
      if2.in_valid   = 1'b1;
      @(posedge clock); #1 if2.in_valid = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clock);
         clear_exp();
         e_rdy = (c >= 6);
         if (c <= 6) begin
            e_dv = 1'b1; e_ev = (c == 6); e_idx = 3'(c - 1);
            e_ser = 16'(c); e_term = blk(c);
         end
         checks++;
         if ({if2.dv, if2.ev, if2.ee, if2.in_ready, if2.hit_idx, if2.out_ser, if2.c_term} !==
             {e_dv, e_ev, e_ee, e_rdy, e_idx, e_ser, e_term}) begin
            failures++;
            $display("FAIL lat0 c=%0d got dv=%b ev=%b ee=%b rdy=%b idx=%0d ser=%h term=%h, expected dv=%b ev=%b ee=%b rdy=%b idx=%0d ser=%h term=%h",
                     c, if2.dv, if2.ev, if2.ee, if2.in_ready, if2.hit_idx, if2.out_ser, if2.c_term,
                     e_dv, e_ev, e_ee, e_rdy, e_idx, e_ser, e_term);
         end
      end
   endtask

   task automatic test_n8();
      @(posedge clock); #1;
      if3.comb_data  = hits12(12'h100);
      if3.hit_mask   = 8'hFF;
      if3.const_data = cvec;
      if3.comb_ee    = 1'b0;
      if3.in_valid   = 1'b1;
      @(posedge clock); #1 if3.in_valid = 1'b0;
      for (int c = 1; c <= 11; c++) begin
         @(negedge clock);
         clear_exp();
         e_rdy = (c >= 8);
         if (c >= 3 && c <= 10) begin
            e_dv = 1'b1; e_ev = (c == 10); e_idx = 3'(c - 3);
            e_ser = 16'(12'h100 + c - 3); e_term = blk(c - 2);
         end
         checks++;
         if ({if3.dv, if3.ev, if3.ee, if3.in_ready, if3.hit_idx, if3.out_ser, if3.c_term} !==
             {e_dv, e_ev, e_ee, e_rdy, e_idx, e_ser[11:0], e_term}) begin
            failures++;
            $display("FAIL n8 c=%0d got dv=%b ev=%b ee=%b rdy=%b idx=%0d ser=%h term=%h, expected dv=%b ev=%b ee=%b rdy=%b idx=%0d ser=%h term=%h",
                     c, if3.dv, if3.ev, if3.ee, if3.in_ready, if3.hit_idx, if3.out_ser, if3.c_term,
                     e_dv, e_ev, e_ee, e_rdy, e_idx, e_ser[11:0], e_term);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired before the summary");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int b = 0; b < 9; b++) cvec[b*108 +: 108] = blk(b);
      if0.in_valid = 1'b0; if0.comb_ee = 1'b0; if0.comb_data = '0; if0.hit_mask = '0; if0.const_data = '0;
      if1.in_valid = 1'b0; if1.comb_ee = 1'b0; if1.comb_data = '0; if1.hit_mask = '0; if1.const_data = '0;
      if2.in_valid = 1'b0; if2.comb_ee = 1'b0; if2.comb_data = '0; if2.hit_mask = '0; if2.const_data = '0;
      if3.in_valid = 1'b0; if3.comb_ee = 1'b0; if3.comb_data = '0; if3.hit_mask = '0; if3.const_data = '0;
      clear_exp();

      test_reset();
      test_single();
      test_back_to_back();
      test_end_event();
      test_skip();
      test_lat0();
      test_n8();
      test_reset_mid_emit();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serializzatore_gen.md
SERIALIZZATORE_GEN -- requirements
Module: serializzatore_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- N_HIT, 6: hits per combination.
- HIT_W, 16: hit word width.
- N_CONST, 6: constant terms per hit.
- CONST_W, 18: constant term width.
- PIPE_LAT, 2: output delay in cycles, 0..4.
- SKIP_EN, 0: 1 = masked hits are not emitted.
REQ-002 Ports SHALL be (name direction width meaning):
- clock in 1: single clock.
- reset in 1: synchronous, active-high.
- in_valid in 1: combination offered.
- in_ready out 1: combination accepted when in_valid & in_ready.
- comb_ee in 1: offered word is an end-event marker, not a combination.
- comb_data in N_HIT*HIT_W: hits; hit k at [k*HIT_W +: HIT_W].
- hit_mask in N_HIT: 1 = hit k present.
- const_data in (N_HIT+1)*N_CONST*CONST_W: block 0 = offset terms; block k+1 = terms for hit k.
- out_ser out HIT_W: serialized hit.
- dv out 1: out_ser valid.
- ev out 1: last cycle of a combination.
- ee out 1: end-event pulse.
- hit_idx out clog2(N_HIT): index of the hit on out_ser.
- c_term out N_CONST*CONST_W: constants aligned with out_ser.
- c_offset out N_CONST*CONST_W: offset block of the current combination.

Function
REQ-003 The FSM SHALL have states IDLE, EMIT and EE_OUT, plus a hit counter idx.
REQ-004 in_ready SHALL be 1 in IDLE, and 1 in EMIT only on the cycle that issues the last selected hit. It SHALL be 0 otherwise.
REQ-005 On accept with comb_ee=0:
- comb_data, hit_mask and const_data SHALL all be registered in the same cycle.
- idx SHALL load with the first selected hit; the next state is EMIT.
REQ-006 On accept with comb_ee=1, the block SHALL go to EE_OUT for one cycle, issuing ee=1 and dv=0, then return to IDLE.
REQ-007 In EMIT, one hit SHALL be issued per cycle, in ascending index order.
- SKIP_EN=0: all N_HIT hits are issued.
- SKIP_EN=1: only hits with hit_mask=1 are issued.
REQ-008 In the SKIP_EN=1 case where hit_mask is all zero, the block SHALL issue one cycle with dv=0 and ev=1, then be ready again.
REQ-009 ev SHALL be 1 on the cycle carrying the last issued hit.
REQ-010 Back-to-back: if in_valid=1 on the last-hit cycle, the next combination SHALL be accepted with no bubble; its first hit is issued on the following cycle.
REQ-011 Issued hit k SHALL be out_ser = comb_data[k*HIT_W +: HIT_W], and c_term SHALL be block k+1 of const_data, unmodified.
REQ-012 c_offset SHALL hold block 0 from the accept cycle until the next accept.
REQ-013 Latency: accept at cycle T SHALL put the first hit on the outputs at T+1+PIPE_LAT. Pipeline alignment:
- out_ser, dv, ev, ee, hit_idx and c_term SHALL travel one shared PIPE_LAT-deep pipeline.
- c_term SHALL be selected before the pipeline, so hit and constants are never misaligned.
REQ-014 When dv=0, out_ser and c_term SHALL be driven to zero.
REQ-015 in_valid=0 SHALL never stall EMIT. The block SHALL have no output backpressure.

Reset
REQ-016 Reset SHALL force:
- state IDLE and idx 0;
- all data registers to 0;
- every pipeline stage to dv=ev=ee=0 and data 0.
REQ-017 After reset deassertion, in_ready SHALL be 1 on the first cycle.
REQ-018 Reset mid-EMIT SHALL abandon the combination. No partial hit and no ev SHALL appear at the outputs after reset release.

Structure
REQ-019 Package serializzatore_pkg SHALL hold:
- the default values of the parameters;
- the state encoding;
- a function computing the first and next selected index from a mask.
REQ-020 The PIPE_LAT delay line SHALL be one sub-module, ser_delay_line, parameterised in width and depth (depth 0 = wire). It is instantiated once for the output bundle.

Verification
REQ-021 The bench SHALL cover these scenarios (defaults unless stated):
- Single combination, hits 0x0001..0x0006, mask 0x3F, accepted at T → out_ser 0x0001..0x0006 at T+3..T+8; ev only at T+8; c_term = blocks 1..6.
- Back-to-back: two combinations, in_valid held high → 12 consecutive dv cycles; ev at cycles 6 and 12.
- SKIP_EN=1, mask 0b100101 → hits 0, 2, 5 emitted, hit_idx 0, 2, 5; ev on hit 5. Mask 0 → one cycle with ev=1, dv=0.
- comb_ee=1 accepted at T → ee=1 at T+3 only; dv=0 throughout.
- Reset asserted on the third hit of EMIT → no ev and no further dv after release; in_ready=1 on the first cycle after release.
- PIPE_LAT=0 → first hit at T+1. N_HIT=8, HIT_W=12 → 8 hits with correct const blocks.
